wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port (RegWrite/rd/Write_Data) between two writeback sources.
  - Source A is the in-order pipeline writeback stage.
  - Source B is the long-latency unit (load miss / multi-cycle mul-div).
- B results are buffered in a small FIFO.
- A normally has priority. A starvation counter guarantees B forward progress.
- Writes to x0 are accepted from either source and then discarded.

Parameters:
- DATA_W, 64, write data width.
- ADDR_W, 5, register index width.
- FIFO_DEPTH, 4, B buffer entries (power of 2, at least 2).
- STARVE_LIMIT, 3, consecutive cycles B's head may lose to A before B is forced through.

Ports:
- clock, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- flush, in, 1, synchronous clear of the B buffer and arbitration state.
- a_valid, in, 1, A has a result.
- a_ready, out, 1, A result is accepted this cycle.
- a_rd, in, ADDR_W, A destination register.
- a_data, in, DATA_W, A result.
- b_valid, in, 1, B has a result.
- b_ready, out, 1, B result is accepted into the FIFO this cycle.
- b_rd, in, ADDR_W, B destination register.
- b_data, in, DATA_W, B result.
- rf_we, out, 1, connects to register file RegWrite.
- rf_rd, out, ADDR_W, connects to register file rd.
- rf_wdata, out, DATA_W, connects to register file Write_Data.
- b_count, out, clog2(FIFO_DEPTH)+1, current B FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - FIFO empty, b_count=0, starve_cnt=0.
  - a_ready=0 and b_ready=0, forced combinationally while reset is low.
- Handshakes: a transfer happens on a rising edge with valid=1 and ready=1. Neither ready depends on its own valid.
- b_ready = (b_count < FIFO_DEPTH) && !flush.
  - Full FIFO: b_ready=0 even if a pop occurs the same cycle. No pass-through.
  - A B handshake with b_rd=0 is accepted but not pushed.
- force_b = (starve_cnt == STARVE_LIMIT) && (b_count != 0).
- a_ready = !force_b && !flush.
  - An A handshake with a_rd=0 is accepted but does not occupy the port.
- Per-cycle grant, evaluated when flush=0:
  1. force_b=1: grant B head.
  2. A handshake with a_rd!=0: grant A.
  3. b_count!=0: grant B head (this includes A idle or A writing x0).
  4. Otherwise: no grant.
- Output register: on an edge with a grant, rf_we<=1 and rf_rd/rf_wdata<=the granted source's rd/data.
  - Without a grant: rf_we<=0; rf_rd and rf_wdata hold their values.
  - Latency: a handshake at edge N gives rf_we=1 during cycle N+1, and the register file writes at edge N+1.
- B latency: an entry pushed at edge N is first eligible at edge N+1 (no empty-FIFO bypass). Minimum 2 edges from b_valid to the RF write.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Simultaneous push and pop leaves b_count unchanged.
  - Entries are popped strictly in order.
- starve_cnt:
  - Resets to 0 on any B grant, or whenever b_count==0.
  - Increments when b_count!=0 and A is granted.
  - Saturates at STARVE_LIMIT.
- flush=1:
  - No grant; rf_we<=0 next edge.
  - FIFO is emptied (b_count<=0) and starve_cnt<=0.
  - a_ready=0, b_ready=0.
  - flush takes precedence over all simultaneous events.
- Ordering:
  - The arbiter does not reorder or compare rd between sources.
  - Same-rd hazards between A and B are resolved by issue logic upstream.
  - Within B, order is preserved.
- Reset asserted mid-operation: pending FIFO contents are lost, and rf_we drops immediately (asynchronous).

Test Plan:
- Reset then idle:
  - Release reset with no valids: rf_we=0, b_count=0, a_ready=1, b_ready=1.
  - With rd=7, data=0x11 on A and on B in separate cycles, each appears once on rf_rd=7/rf_wdata=0x11 with the latencies stated in Behaviour (1 edge for A, 2 edges for B).
- Priority and starvation:
  - Stimulus: B pushes rd=5, data=0xAA, then A is valid every cycle with rd=1..6.
  - Required: A is granted for 3 cycles after B's head becomes eligible.
  - Then a_ready=0 for one cycle, rf_rd=5/0xAA is written, and A resumes.
- x0 handling: A is valid with rd=0 while the B head holds rd=9. Required: a_ready=1, and B is written the same cycle (rf_rd=9). No write to x0 ever appears on rf_we.
- FIFO full and wrap:
  - Stimulus: push 4 B entries while A saturates the port with STARVE_LIMIT large.
  - Required: b_ready=0 at b_count=4.
  - Then drain and push 6 more; the entries pop in exact order across the pointer wrap.
- Flush: with b_count=3, assert flush for 1 cycle. Required: b_count=0, rf_we=0 next cycle, and the flushed entries are never written.
- Async reset mid-stream: drop reset while rf_we=1 and b_count=2. Required: rf_we=0 immediately, without waiting for a clock edge, and b_count=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback (A)
// and a FIFO-buffered long-latency source (B), with a starvation guard for B.
module wb_port_arbiter #(
   parameter int DATA_W       = 64,
   parameter int ADDR_W       = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            flush,
   input  logic                            a_valid,
   output logic                            a_ready,
   input  logic [ADDR_W-1:0]               a_rd,
   input  logic [DATA_W-1:0]               a_data,
   input  logic                            b_valid,
   output logic                            b_ready,
   input  logic [ADDR_W-1:0]               b_rd,
   input  logic [DATA_W-1:0]               b_data,
   output logic                            rf_we,
   output logic [ADDR_W-1:0]               rf_rd,
   output logic [DATA_W-1:0]               rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0]     b_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [ADDR_W-1:0] mem_rd   [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [SW-1:0]     starve_cnt, starve_n;
   logic              b_nonempty, force_b, grant_a, grant_b, push;
   // count == FIFO_DEPTH exactly when its MSB is set, since depth is a power of 2
   always_comb begin
      b_nonempty = b_count != '0;
      force_b    = (starve_cnt == SW'(STARVE_LIMIT)) && b_nonempty;
      a_ready    = reset && !force_b && !flush;
      b_ready    = reset && !flush && !b_count[CW-1];
      grant_a    = a_valid && a_ready && (a_rd != '0);
      grant_b    = reset && !flush && b_nonempty && !grant_a;
      push       = b_valid && b_ready && (b_rd != '0);
      starve_n   = (!b_nonempty || grant_b) ? '0 :
                   (grant_a && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rf_we      <= 1'b0;
         rf_rd      <= '0;
         rf_wdata   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         b_count    <= '0;
         starve_cnt <= '0;
      end else if (flush) begin
         rf_we      <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         b_count    <= '0;
         starve_cnt <= '0;
      end else begin
         rf_we <= grant_a || grant_b;
         if (grant_a) begin
            rf_rd    <= a_rd;
            rf_wdata <= a_data;
         end else if (grant_b) begin
            rf_rd    <= mem_rd[rd_ptr];
            rf_wdata <= mem_data[rd_ptr];
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (grant_b) rd_ptr <= rd_ptr + 1'b1;
         b_count    <= b_count + CW'(push) - CW'(grant_b);
         starve_cnt <= starve_n;
      end
   end
   always_ff @(posedge clock) begin
      if (push) begin
         mem_rd[wr_ptr]   <= b_rd;
         mem_data[wr_ptr] <= b_data;
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus checked every cycle against a queue-based
// model of the arbitration rules, plus hand-computed literal expectations.
module tb_wb_port_arbiter;
   localparam int DEPTH = 4;
   localparam int LIM   = 3;
   logic        clock = 0, reset = 0, flush = 0;
   logic        a_valid = 0, b_valid = 0;
   logic [4:0]  a_rd = 0, b_rd = 0;
   logic [63:0] a_data = 0, b_data = 0;
   logic        a_ready, b_ready, rf_we;
   logic [4:0]  rf_rd;
   logic [63:0] rf_wdata;
   logic [2:0]  b_count;
   int total = 0, bad = 0;

   wb_port_arbiter #(.DATA_W(64), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .b_count(b_count));

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {logic [4:0] rd; logic [63:0] d;} ent_t;
   ent_t        q[$];
   ent_t        e;
   int          st = 0, n;
   bit          frc, ga, gb;
   logic        m_we = 0;
   logic [4:0]  m_rd = 0;
   logic [63:0] m_wd = 0;

   // model: B entries live in a queue; the write port is granted by the priority rules
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         q.delete(); st = 0; m_we = 0; m_rd = 0; m_wd = 0;
      end else if (flush) begin
         q.delete(); st = 0; m_we = 0;
      end else begin
         n   = q.size();
         frc = (st == LIM) && (n != 0);
         ga  = a_valid && !frc && (a_rd != 0);
         gb  = !ga && (n != 0);
         m_we = ga || gb;
         if (ga) begin
            m_rd = a_rd; m_wd = a_data;
         end else if (gb) begin
            e = q.pop_front(); m_rd = e.rd; m_wd = e.d;
         end
         if (n == 0 || gb) st = 0;
         else if (ga && st < LIM) st++;
         if (b_valid && n < DEPTH && b_rd != 0) q.push_back('{b_rd, b_data});
      end
   end

   always @(negedge clock) begin
      chk("a_ready", a_ready, reset && !flush && !(st == LIM && q.size() != 0));
      chk("b_ready", b_ready, reset && !flush && q.size() < DEPTH);
      chk("b_count", b_count, q.size());
      chk("rf_we", rf_we, m_we);
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_wdata", rf_wdata, m_wd);
      chk("x0_write", rf_we && rf_rd == 0, 0);
   end

   task automatic cyc(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [63:0] bd, input logic fl);
      a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd; flush = fl;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #12;
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_rf_we", rf_we, 0);
      reset = 1;
      #1;
      chk("idle_a_ready", a_ready, 1);
      chk("idle_b_ready", b_ready, 1);
      chk("idle_b_count", b_count, 0);
      // single writes, A latency 1 edge, B latency 2 edges
      cyc(1, 7, 'h11, 0, 0, 0, 0);
      chk("a_lat_we", rf_we, 1);
      chk("a_lat_rd", rf_rd, 7);
      chk("a_lat_wd", rf_wdata, 'h11);
      idle(1);
      cyc(0, 0, 0, 1, 7, 'h11, 0);
      chk("b_push_we", rf_we, 0);
      chk("b_push_cnt", b_count, 1);
      idle(1);
      chk("b_lat_we", rf_we, 1);
      chk("b_lat_rd", rf_rd, 7);
      chk("b_lat_wd", rf_wdata, 'h11);
      idle(1);
      // starvation: A wins 3 times, then B is forced through
      cyc(0, 0, 0, 1, 5, 'hAA, 0);
      cyc(1, 1, 'h101, 0, 0, 0, 0);
      cyc(1, 2, 'h102, 0, 0, 0, 0);
      cyc(1, 3, 'h103, 0, 0, 0, 0);
      chk("starve_rd3", rf_rd, 3);
      chk("starve_a_ready", a_ready, 0);
      cyc(1, 4, 'h104, 0, 0, 0, 0);
      chk("forced_rd", rf_rd, 5);
      chk("forced_wd", rf_wdata, 'hAA);
      chk("resume_a_ready", a_ready, 1);
      cyc(1, 4, 'h104, 0, 0, 0, 0);
      chk("resume_rd", rf_rd, 4);
      cyc(1, 5, 'h105, 0, 0, 0, 0);
      cyc(1, 6, 'h106, 0, 0, 0, 0);
      idle(1);
      // A writing x0 lets the B head through in the same cycle
      cyc(0, 0, 0, 1, 9, 'h99, 0);
      chk("x0_a_ready", a_ready, 1);
      cyc(1, 0, 'h55, 0, 0, 0, 0);
      chk("x0_b_we", rf_we, 1);
      chk("x0_b_rd", rf_rd, 9);
      idle(1);
      // fill FIFO while A saturates, then drain and wrap
      for (int k = 0; k < 4; k++) cyc(1, 5'(k + 1), 64'h200 + k, 1, 5'(20 + k), 64'h300 + k, 0);
      chk("full_cnt", b_count, 4);
      chk("full_b_ready", b_ready, 0);
      idle(5);
      chk("drained_cnt", b_count, 0);
      for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 5'(24 + k), 64'h400 + k, 0);
      idle(3);
      // flush with three entries pending
      for (int k = 0; k < 3; k++) cyc(1, 5'(k + 1), 64'h500 + k, 1, 5'(10 + k), 64'h600 + k, 0);
      chk("pre_flush_cnt", b_count, 3);
      cyc(1, 4, 'h504, 1, 13, 'h603, 1);
      chk("flush_cnt", b_count, 0);
      chk("flush_we", rf_we, 0);
      idle(3);
      chk("post_flush_we", rf_we, 0);
      // asynchronous reset while writing with two entries pending
      cyc(1, 1, 'h701, 1, 10, 'h801, 0);
      cyc(1, 2, 'h702, 1, 11, 'h802, 0);
      chk("pre_rst_cnt", b_count, 2);
      chk("pre_rst_we", rf_we, 1);
      a_valid = 0; b_valid = 0;
      #2;
      reset = 0;
      #1;
      chk("async_we", rf_we, 0);
      chk("async_cnt", b_count, 0);
      chk("async_a_ready", a_ready, 0);
      #3;
      reset = 1;
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
